// File: rtl/if_sequencer.sv
// -----------------------------------------------------------------------------
// if_sequencer
//
// Instruction sequencer sitting between the host command FIFO and NCH MUX
// channels. Instructions are popped from a first-word-fall-through FIFO,
// latched, and decoded on the following cycle. Depending on the 4-bit opcode
// the sequencer issues a payload to the selected MUX channel (waiting for that
// channel to report idle), loads or starts a wide wait timer, or halts until
// resumed. Illegal opcodes and out-of-range channel issues raise a sticky
// error. Every decoded instruction bumps a 16-bit wrapping counter.
//
// Ports:
//   fpga_clk_i    - single clock
//   reset_n_i     - synchronous, active-low reset
//   run_i         - level; new fetches are only started while high
//   abort_i       - synchronous abort, overrides every transition
//   resume_i      - leaves HALT
//   fifo_empty_i  - FIFO empty; fifo_data_i is valid whenever this is low
//   fifo_data_i   - FIFO head instruction (FWFT)
//   fifo_rd_o     - one-cycle pop strobe
//   mux_data_o    - payload of the most recent issue (held between issues)
//   mux_en_o      - one-hot, one-cycle issue strobe
//   mux_idle_i    - per-channel idle
//   busy_o        - high in any state other than IDLE
//   halted_o      - high in HALT
//   err_o         - sticky error, cleared by reset only
//   ins_count_o   - executed-instruction counter, wraps 0xFFFF -> 0
//
// Instruction word: opcode = ins[31:28], payload = ins[27:0].
// -----------------------------------------------------------------------------
module if_sequencer #(
    parameter int DATA_W  = 28,
    parameter int TIMER_W = 48,
    parameter int NCH     = 4
) (
    input  logic              fpga_clk_i,
    input  logic              reset_n_i,
    input  logic              run_i,
    input  logic              abort_i,
    input  logic              resume_i,
    input  logic              fifo_empty_i,
    input  logic [31:0]       fifo_data_i,
    output logic              fifo_rd_o,
    output logic [DATA_W-1:0] mux_data_o,
    output logic [NCH-1:0]    mux_en_o,
    input  logic [NCH-1:0]    mux_idle_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [15:0]       ins_count_o
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    // One extra bit so the channel count itself is representable (NCH = 16).
    localparam logic [CH_W:0] NCH_LIM = (CH_W + 1)'(NCH);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ISSUE = 4'h1;
    localparam logic [3:0] OP_LOADL = 4'h2;
    localparam logic [3:0] OP_LOADH = 4'h3;
    localparam logic [3:0] OP_SETCH = 4'h4;
    localparam logic [3:0] OP_WAIT  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'h6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_ISSUE,
        S_TIMER,
        S_HALT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [31:0]          ins;
    logic [CH_W-1:0]      ch;
    logic [TIMER_W-1:0]   timer_target;
    logic [TIMER_W-1:0]   timer_q;

    logic [3:0]           opcode;
    logic [NCH-1:0]       ch_onehot;
    logic                 ch_idle;
    logic                 ch_bad;

    // Per-cycle actions decided by the control process.
    logic                 fetch;
    logic                 exec_done;
    logic                 issue_fire;
    logic                 set_err;
    logic                 load_lo;
    logic                 load_hi;
    logic                 load_ch;
    logic                 timer_clr;
    logic                 timer_inc;

    assign opcode    = ins[31:28];
    // An out-of-range channel shifts the bit off the end, so the one-hot is
    // all zeros and can never select a channel.
    assign ch_onehot = NCH'(1) << ch;
    assign ch_idle   = |(mux_idle_i & ch_onehot);
    assign ch_bad    = {1'b0, ch} >= NCH_LIM;

    assign busy_o    = (state != S_IDLE);
    assign halted_o  = (state == S_HALT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of process order.
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and action decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        exec_done  = 1'b0;
        issue_fire = 1'b0;
        set_err    = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        load_ch    = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;

        case (state)
            S_IDLE: begin
                if (run_i && !fifo_empty_i) begin
                    fetch      = 1'b1;
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                exec_done  = 1'b1;
                state_next = S_IDLE;
                case (opcode)
                    OP_NOP:   ;
                    OP_ISSUE: begin
                        // Range is checked here rather than at SETCH so a
                        // bad channel only matters if it is actually used.
                        if (ch_bad) set_err    = 1'b1;
                        else        state_next = S_ISSUE;
                    end
                    OP_LOADL: load_lo = 1'b1;
                    OP_LOADH: load_hi = 1'b1;
                    OP_SETCH: load_ch = 1'b1;
                    OP_WAIT: begin
                        timer_clr  = 1'b1;
                        state_next = S_TIMER;
                    end
                    OP_HALT:  state_next = S_HALT;
                    default:  set_err = 1'b1;
                endcase
            end

            S_ISSUE: begin
                if (ch_idle) begin
                    issue_fire = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_TIMER: begin
                // Counting 0..target inclusive gives target+1 cycles here.
                if (timer_q == timer_target) begin
                    timer_clr  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    timer_inc  = 1'b1;
                end
            end

            S_HALT: begin
                if (resume_i) state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase

        // Abort overrides everything: no strobes, no side effects beyond
        // clearing the running timer.
        if (abort_i) begin
            state_next = S_IDLE;
            fetch      = 1'b0;
            exec_done  = 1'b0;
            issue_fire = 1'b0;
            set_err    = 1'b0;
            load_lo    = 1'b0;
            load_hi    = 1'b0;
            load_ch    = 1'b0;
            timer_inc  = 1'b0;
            timer_clr  = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_n_i) begin
            ins          <= '0;
            ch           <= '0;
            timer_target <= '0;
            timer_q      <= '0;
            fifo_rd_o    <= 1'b0;
            mux_en_o     <= '0;
            mux_data_o   <= '0;
            err_o        <= 1'b0;
            ins_count_o  <= '0;
        end else begin
            // Strobes are registered so they last exactly one cycle.
            fifo_rd_o <= fetch;
            mux_en_o  <= issue_fire ? ch_onehot : '0;

            if (fetch) begin
                ins <= fifo_data_i;
            end else if (abort_i) begin
                ins <= '0;
            end

            if (issue_fire) mux_data_o <= ins[DATA_W-1:0];
            if (exec_done)  ins_count_o <= ins_count_o + 16'd1;
            if (set_err)    err_o <= 1'b1;
            if (load_ch)    ch <= ins[CH_W-1:0];
            if (load_lo)    timer_target[23:0] <= ins[23:0];
            if (load_hi)    timer_target[TIMER_W-1:24] <= ins[TIMER_W-25:0];

            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
        end
    end

endmodule
